// File: rtl/alu_pkg.sv
// Shared constants for the ALU op sequencer: ALU ctrl codes, instruction
// field positions, FSM state encoding and flag bit indices.
package alu_pkg;

  localparam int ALU_W   = 18;
  localparam int INSTR_W = 18;
  localparam int REG_AW  = 3;

  localparam logic [2:0] CTRL_PASSA = 3'd0;
  localparam logic [2:0] CTRL_PASSB = 3'd1;
  localparam logic [2:0] CTRL_NOTA  = 3'd2;
  localparam logic [2:0] CTRL_ADD   = 3'd3;
  localparam logic [2:0] CTRL_SUB   = 3'd4;
  localparam logic [2:0] CTRL_OR    = 3'd5;
  localparam logic [2:0] CTRL_AND   = 3'd6;

  localparam logic [2:0] OP_CMP = 3'd7;

  localparam int OP_LSB      = 15;
  localparam int RD_LSB      = 12;
  localparam int RA_LSB      = 9;
  localparam int RB_LSB      = 6;
  localparam int IMM_SEL_BIT = 5;
  localparam int IMM_LSB     = 0;
  localparam int IMM_W       = 5;

  localparam int FLAG_Z    = 0;
  localparam int FLAG_N    = 1;
  localparam int FLAG_AGTB = 2;
  localparam int FLAG_OVF  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } seq_state_t;

  // CMP runs as a subtract so the ALU's unused code 7 is never driven.
  function automatic logic [2:0] ctrl_of_op(input logic [2:0] op);
    return (op == OP_CMP) ? CTRL_SUB : op;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Instruction handshake plus ALU operand/result bus between the sequencer
// (master) and the instruction source / combinational ALU (slave).
interface alu_op_sequencer_if #(
  parameter int DATA_W = 18
);
  logic              instr_valid;
  logic [17:0]       instr;
  logic              instr_ready;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_ctrl;
  logic              alu_en;
  logic [DATA_W-1:0] alu_result;
  logic              alu_n;
  logic              alu_z;
  logic              alu_ovf;
  logic              alu_agtb;
  logic [3:0]        flags;
  logic              done;

  modport master (
    input  instr_valid, instr, alu_result, alu_n, alu_z, alu_ovf, alu_agtb,
    output instr_ready, alu_a, alu_b, alu_ctrl, alu_en, flags, done
  );

  modport slave (
    output instr_valid, instr, alu_result, alu_n, alu_z, alu_ovf, alu_agtb,
    input  instr_ready, alu_a, alu_b, alu_ctrl, alu_en, flags, done
  );
endinterface

// File: rtl/regfile_8x18.sv
// Register file: two combinational read ports, a debug read port and one
// synchronous write port; cleared synchronously on rst.
module regfile_8x18 #(
  parameter int DATA_W = 18,
  parameter int NREG   = 8,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Four-state initiator for the 18-bit ALU: IDLE -> READ -> EXEC -> WB.
// Optional build macro IMM_OPERAND_EN: instr[5] selects a sign-extended 5-bit immediate as operand B.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_W,
  parameter int NREG   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_op_sequencer_if.master    bus,
  input  logic [REG_AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
);

  seq_state_t state, state_nxt;

  logic [INSTR_W-1:0] instr_q;
  logic [2:0]         op;
  logic [REG_AW-1:0]  rd, ra, rb;
  logic [DATA_W-1:0]  rdata_a, rdata_b, opnd_b;
  logic [DATA_W-1:0]  alu_a_q, alu_b_q;
  logic [2:0]         alu_ctrl_q;
  logic [3:0]         flags_q, flags_in;
  logic               ready_c, alu_en_c, done_c, wb_we;

  assign op = instr_q[OP_LSB +: 3];
  assign rd = instr_q[RD_LSB +: REG_AW];
  assign ra = instr_q[RA_LSB +: REG_AW];
  assign rb = instr_q[RB_LSB +: REG_AW];

  regfile_8x18 #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .AW     (REG_AW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (wb_we),
    .waddr    (rd),
    .wdata    (bus.alu_result),
    .raddr_a  (ra),
    .rdata_a  (rdata_a),
    .raddr_b  (rb),
    .rdata_b  (rdata_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

`ifdef IMM_OPERAND_EN
  assign opnd_b = instr_q[IMM_SEL_BIT]
                ? {{(DATA_W-IMM_W){instr_q[IMM_LSB+IMM_W-1]}}, instr_q[IMM_LSB +: IMM_W]}
                : rdata_b;
`else
  logic unused_imm;
  assign unused_imm = ^instr_q[IMM_SEL_BIT:IMM_LSB];
  assign opnd_b     = rdata_b;
`endif

  always_comb begin
    flags_in            = '0;
    flags_in[FLAG_Z]    = bus.alu_z;
    flags_in[FLAG_N]    = bus.alu_n;
    flags_in[FLAG_AGTB] = bus.alu_agtb;
    flags_in[FLAG_OVF]  = bus.alu_ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Strobes are masked by rst so an aborted operation never pulses done or alu_en.
  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    alu_en_c  = 1'b0;
    done_c    = 1'b0;
    wb_we     = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (bus.instr_valid) begin
          state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        alu_en_c  = !rst;
        state_nxt = ST_WB;
      end
      ST_WB: begin
        done_c    = !rst;
        wb_we     = (op != OP_CMP);
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= CTRL_PASSA;
      flags_q    <= '0;
    end else begin
      if (state == ST_IDLE && bus.instr_valid) begin
        instr_q <= bus.instr;
      end
      if (state == ST_READ) begin
        alu_a_q    <= rdata_a;
        alu_b_q    <= opnd_b;
        alu_ctrl_q <= ctrl_of_op(op);
      end
      if (state == ST_WB) begin
        flags_q <= flags_in;
      end
    end
  end

  assign bus.instr_ready = ready_c;
  assign bus.alu_en      = alu_en_c;
  assign bus.done        = done_c;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_ctrl    = alu_ctrl_q;
  assign bus.flags       = flags_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU on the bus.
// Expected register/flag values below are worked out by hand for each step.
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst;
  logic [2:0]  dbg_addr;
  logic [17:0] dbg_data;

  int total_checks = 0;
  int bad_checks   = 0;

  alu_op_sequencer_if #(.DATA_W(18)) bus ();

  alu_op_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: unsigned agtb, signed overflow on ADD/SUB only.
  logic [17:0] a_m, b_m, r_m;
  always_comb begin
    a_m = bus.alu_a;
    b_m = bus.alu_b;
    r_m = '0;
    bus.alu_ovf = 1'b0;
    case (bus.alu_ctrl)
      3'd0: r_m = a_m;
      3'd1: r_m = b_m;
      3'd2: r_m = ~a_m;
      3'd3: begin
        r_m = a_m + b_m;
        bus.alu_ovf = (a_m[17] == b_m[17]) && (r_m[17] != a_m[17]);
      end
      3'd4: begin
        r_m = a_m - b_m;
        bus.alu_ovf = (a_m[17] != b_m[17]) && (r_m[17] != a_m[17]);
      end
      3'd5: r_m = a_m | b_m;
      3'd6: r_m = a_m & b_m;
      default: r_m = '0;
    endcase
    bus.alu_result = r_m;
    bus.alu_n      = r_m[17];
    bus.alu_z      = (r_m == 18'd0);
    bus.alu_agtb   = (a_m > b_m);
  end

  function automatic logic [17:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] ra, input logic [2:0] rb,
                                      input logic [5:0] imm);
    return {op, rd, ra, rb, imm};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total_checks++;
    if (got !== want) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic checkReg(input string tag, input logic [2:0] idx, input logic [17:0] want);
    dbg_addr = idx;
    #1;
    checkOutput(tag, {14'd0, dbg_data}, {14'd0, want});
  endtask

  // Handshake at cycle 0, alu_en at cycle 2, done at cycle 3, idle again at cycle 4.
  task automatic applyStimulus(input logic [17:0] ins, input logic [2:0] exp_ctrl);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    checkOutput("busy_ready", bus.instr_ready, 0);
    @(negedge clk);
    checkOutput("exec_alu_en", bus.alu_en, 1);
    checkOutput("exec_ctrl", bus.alu_ctrl, exp_ctrl);
    @(negedge clk);
    checkOutput("wb_done", bus.done, 1);
    @(negedge clk);
    checkOutput("idle_done", bus.done, 0);
    checkOutput("idle_ready", bus.instr_ready, 1);
  endtask

  task automatic runOp(input string tag, input logic [17:0] ins, input logic [2:0] exp_ctrl,
                       input logic [2:0] chk_reg, input logic [17:0] exp_reg,
                       input logic [3:0] exp_flags);
    applyStimulus(ins, exp_ctrl);
    checkReg({tag, "_reg"}, chk_reg, exp_reg);
    checkOutput({tag, "_flags"}, bus.flags, exp_flags);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [17:0] ins_a, ins_b;
    logic [17:0] imm_exp_reg;
    logic [3:0]  imm_exp_flags;
    int          accepts;

    rst             = 1'b1;
    dbg_addr        = 3'd0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    checkOutput("rst_ready", bus.instr_ready, 1);
    checkOutput("rst_alu_en", bus.alu_en, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_flags", bus.flags, 0);
    checkOutput("rst_alu_a", bus.alu_a, 0);
    checkOutput("rst_alu_b", bus.alu_b, 0);
    checkOutput("rst_ctrl", bus.alu_ctrl, 0);
    checkReg("rst_r0", 3'd0, 18'd0);

    // Flags are {ovf, agtb, n, z}.
    runOp("nota0",  enc(3'd2, 3'd1, 3'd0, 3'd0, 6'd0), 3'd2, 3'd1, 18'h3FFFF, 4'b0010);
    runOp("sub_one", enc(3'd4, 3'd2, 3'd0, 3'd1, 6'd0), 3'd4, 3'd2, 18'd1,    4'b0000);
    runOp("wrap",   enc(3'd3, 3'd3, 3'd1, 3'd2, 6'd0), 3'd3, 3'd3, 18'd0,     4'b0101);
    runOp("mk2",    enc(3'd3, 3'd3, 3'd2, 3'd2, 6'd0), 3'd3, 3'd3, 18'd2,     4'b0000);
    runOp("mk3",    enc(3'd3, 3'd4, 3'd3, 3'd2, 6'd0), 3'd3, 3'd4, 18'd3,     4'b0100);
    runOp("mk5",    enc(3'd3, 3'd5, 3'd3, 3'd4, 6'd0), 3'd3, 3'd5, 18'd5,     4'b0000);
    runOp("mk7",    enc(3'd3, 3'd6, 3'd5, 3'd3, 6'd0), 3'd3, 3'd6, 18'd7,     4'b0100);
    runOp("add12",  enc(3'd3, 3'd3, 3'd5, 3'd6, 6'd0), 3'd3, 3'd3, 18'd12,    4'b0000);
    runOp("subz",   enc(3'd4, 3'd4, 3'd5, 3'd5, 6'd0), 3'd4, 3'd4, 18'd0,     4'b0001);
    runOp("cmp",    enc(3'd7, 3'd7, 3'd6, 3'd5, 6'd0), 3'd4, 3'd7, 18'd0,     4'b0100);
    runOp("hazard", enc(3'd3, 3'd5, 3'd5, 3'd5, 6'd0), 3'd3, 3'd5, 18'd10,    4'b0000);
    runOp("dep",    enc(3'd3, 3'd0, 3'd5, 3'd0, 6'd0), 3'd3, 3'd0, 18'd10,    4'b0100);

`ifdef IMM_OPERAND_EN
    imm_exp_reg   = 18'd8;
    imm_exp_flags = 4'b0000;
`else
    imm_exp_reg   = 18'd11;
    imm_exp_flags = 4'b0100;
`endif
    runOp("imm", enc(3'd3, 3'd1, 3'd0, 3'd2, 6'b111110), 3'd3, 3'd1, imm_exp_reg, imm_exp_flags);

    // Valid held for 10 cycles: accepts expected at cycles 0, 4 and 8 only.
    ins_a   = enc(3'd3, 3'd7, 3'd2, 3'd2, 6'd0);
    ins_b   = enc(3'd3, 3'd6, 3'd6, 3'd2, 6'd0);
    accepts = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.instr       = (i < 3) ? ins_a : ins_b;
      checkOutput("hs_ready", bus.instr_ready, ((i % 4) == 0) ? 32'd1 : 32'd0);
      if (bus.instr_ready) accepts++;
    end
    @(negedge clk);
    bus.instr_valid = 1'b0;
    for (int k = 0; k < 8 && !bus.instr_ready; k++) @(negedge clk);
    checkOutput("hs_drain", bus.instr_ready, 1);
    checkOutput("hs_accepts", accepts, 3);
    checkReg("hs_r7", 3'd7, 18'd2);
    checkReg("hs_r6", 3'd6, 18'd9);

    // Reset during EXEC of ADD r3 = r0 + r0 must abort the writeback.
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = enc(3'd3, 3'd3, 3'd0, 3'd0, 6'd0);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rx_alu_en", bus.alu_en, 1);
    checkOutput("rx_alu_a", bus.alu_a, 18'd10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput("rx_no_done", bus.done, 0);
      checkOutput("rx_no_en", bus.alu_en, 0);
      @(negedge clk);
    end
    checkReg("rx_r3", 3'd3, 18'd0);
    checkReg("rx_r0", 3'd0, 18'd0);
    checkOutput("rx_flags", bus.flags, 0);
    checkOutput("rx_alu_a0", bus.alu_a, 0);
    checkOutput("rx_alu_b0", bus.alu_b, 0);
    checkOutput("rx_ctrl", bus.alu_ctrl, 0);
    checkOutput("rx_ready", bus.instr_ready, 1);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Initiator side of the 18-bit ALU interface. Accepts one encoded 18-bit instruction per valid/ready handshake and reads operands from an internal 8x18 register file. It drives ALU operands, ctrl code and enable, then captures the ALU result and flags. It writes the result back and reports completion. It sits between the instruction fetch path and the combinational ALU.

Parameters:
DATA_W, 18, datapath width (ALU operand/result width)
NREG, 8, register file depth (index width 3)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
instr_valid  in  1  instruction offered
instr  in  18  [17:15] op, [14:12] rd, [11:9] ra, [8:6] rb, [5:0] imm field
instr_ready  out  1  sequencer can accept (high only in IDLE)
alu_a  out  18  ALU operand A
alu_b  out  18  ALU operand B
alu_ctrl  out  3  ALU op code
alu_en  out  1  ALU enable
alu_result  in  18  ALU output
alu_n / alu_z / alu_ovf / alu_agtb  in  1 each  ALU flags
flags  out  4  registered {ovf, agtb, n, z}
done  out  1  one-cycle pulse at writeback
dbg_addr  in  3  debug read index
dbg_data  out  18  combinational read of reg[dbg_addr]

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset: FSM to IDLE; all registers = 0; alu_a = alu_b = 0; alu_ctrl = 0; alu_en = 0; flags = 0; done = 0; instr_ready = 1 on the first cycle after reset.
- FSM states:
  - IDLE: instr_ready = 1. On instr_valid, latch instr and go to READ.
  - READ: register alu_a = reg[ra], alu_b = reg[rb] and alu_ctrl. Go to EXEC.
  - EXEC: alu_en = 1 for exactly this cycle. Go to WB.
  - WB: capture alu_result into reg[rd] and the 4 flags into flags; done = 1. Go to IDLE.
- Latency: handshake at cycle 0, done at cycle 3. Result is visible on dbg_data at cycle 4. Throughput is one instruction per 4 cycles.
- Op mapping:
  - 0 PASSA, 1 PASSB, 2 NOTA, 3 ADD, 4 SUB, 5 OR, 6 AND: alu_ctrl = op.
  - 7 CMP: alu_ctrl = 4. Flags are updated but there is no register write.
- alu_ctrl is never driven to 7, so the ALU's undriven-output code is never exercised.
- instr_valid while instr_ready = 0 is ignored; there is no queueing, and the source must hold its request.
- Hazards:
  - rd == ra or rd == rb: operands are read in READ, before the WB write, so the old value is used.
  - Back-to-back dependent instructions see the written value, because the read occurs ≥1 cycle after WB.
- Arithmetic: no width extension; ALU wrap-around results are stored unmodified; ovf is taken from the ALU as-is.
- alu_a, alu_b and alu_ctrl hold their values outside EXEC; alu_en is 0 outside EXEC.
- Reset mid-operation (READ/EXEC/WB) aborts: no writeback, no done pulse, full reset values.

Optional Feature:
- IMM_OPERAND_EN defined:
  - instr[5] = 1 selects operand B = sign-extended instr[4:0] (−16..15 to 18 bits) instead of reg[rb].
  - rb is ignored when instr[5] = 1.
- Undefined: instr[5:0] is ignored; operand B is always reg[rb].

Decomposition:
- Shared package alu_pkg:
  - ALU ctrl localparams (CTRL_PASSA..CTRL_AND = 0..6).
  - OP_CMP = 7.
  - Instruction field bit positions.
  - FSM state encoding (IDLE, READ, EXEC, WB).
  - Flag bit indices.
- One sub-module: regfile_8x18.
  - Two combinational read ports plus a debug read port.
  - One synchronous write port.
  - Synchronous clear on rst.

Test Plan:
- Reset, then ADD:
  - Preload r1 = 5, r2 = 7 (via PASSB from imm or prior ops).
  - op = 3, rd = 3, ra = 1, rb = 2.
  - Expect alu_en high at cycle 2 with ctrl = 3; done at cycle 3; reg[3] = 12; flags z = 0, n = 0.
- SUB to zero, then CMP:
  - SUB r4 = r1 − r1 → reg[4] = 0, z = 1.
  - CMP r2, r1 (7 vs 5) → agtb = 1, flags updated, reg[rd] unchanged, alu_ctrl = 4.
- Wrap-around:
  - r1 = 18'h3FFFF, r2 = 1, ADD → reg[rd] = 0, z = 1.
  - NOTA of 0 → 18'h3FFFF, n = 1.
- Handshake:
  - Hold instr_valid high for 10 cycles with two different instr values.
  - instr_ready is high only in IDLE; exactly one accept per 4 cycles.
  - No instruction is accepted while busy.
- Reset in EXEC:
  - Assert rst during alu_en = 1.
  - Expect no done pulse, target register = 0, all outputs at reset values.
- With IMM_OPERAND_EN:
  - ADD rd = 1, ra = 0, instr[5:0] = 6'b1_11110 (imm −2), with r0 = 10.
  - Expect reg[1] = 8.
  - Without the macro, the same encoding uses reg[rb].
